median_window_ctrl: RTL and testbench
=====================================

// Module: median_window_ctrl
// PURPOSE
// Frame-level sequencer for the 3x3 median datapath (median_filter_w3x3). Accepts a raster pixel
// stream, keeps two line buffers, and presents each complete 3x3 window on oP11..oP33.
// Tags the datapath's oMedianValue with a delayed valid and emits the filtered interior image.
// Border rows/columns are dropped: output is (IMG_W-2)x(IMG_H-2) pixels per frame.
// PARAMETERS
// DW      8    pixel width in bits
// IMG_W   640  pixels per line (>=3)
// IMG_H   480  lines per frame (>=3)
// MED_LAT 3    clock latency of the median datapath, window-in to oMedianValue (>=1)
// PORTS
// iClk          in   1     clock
// iRst_n        in   1     asynchronous active-low reset
// iStart        in   1     1-cycle pulse: begin a frame (honoured only in IDLE)
// iPixel        in   DW    input pixel, raster order
// iPixelValid   in   1     iPixel valid; accepted when iPixelValid && oPixelReady
// oPixelReady   out  1     high in FILL and RUN
// oP11..oP33    out  DW ea window to datapath; row 1 = line r-2, row 3 = line r; col 1 = c-2, col 3 = c
// iMedianValue  in   DW    median from datapath
// oPixel        out  DW    filtered output pixel
// oPixelValid   out  1     oPixel valid (no back-pressure; sink always accepts)
// oBusy         out  1     high from the first cycle after iStart until DONE
// oDone         out  1     1-cycle pulse after the last output pixel
// BEHAVIOUR
// - Reset (async, any state): FSM->IDLE; col/row counters, valid delay line, and all outputs = 0.
//   Line-buffer RAM contents are not cleared.
// - FSM: IDLE -(iStart)-> FILL -(accept at row 2, col 2)-> RUN
//   -(accept at row IMG_H-1, col IMG_W-1)-> DRAIN -(MED_LAT cycles)-> DONE -> IDLE.
// - DONE lasts 1 cycle; oDone=1 there, oBusy=0 in IDLE and DONE.
// - Counters col 0..IMG_W-1, row 0..IMG_H-1 advance only on accept.
//   col wraps to 0 and row increments at col=IMG_W-1.
// - Line buffers: LB1 holds line r-1, LB0 holds line r-2. On accept at col c:
//   LB0[c]<=LB1[c], LB1[c]<=iPixel.
//   Read-before-write at the same address.
// - Window: a 3-column shift register per row, shifted on accept with {LB0[c],LB1[c],iPixel}.
//   Shift registers reset at col 0, so no window ever spans a line wrap.
// - Window valid (internal wv) = accept && row>=2 && col>=2. oP* update on accept and hold
//   otherwise, becoming stable the cycle after the accept.
// - wv enters a MED_LAT-deep shift register; oPixelValid = its tail. oPixel = iMedianValue,
//   registered in the same cycle the tail is 1; otherwise oPixel holds.
// - Stalls: iPixelValid low for any number of cycles freezes counters and windows.
//   The valid pipe keeps shifting zeros. Bubbles in output equal bubbles in input.
// - oPixelReady=0 in IDLE/DRAIN/DONE; pixels offered then are ignored, not accepted.
// - iStart while oBusy is ignored. iStart in the DONE cycle is ignored; it is honoured from IDLE.
// - Output count per frame is exactly (IMG_W-2)*(IMG_H-2). The last oPixelValid occurs in the
//   final DRAIN cycle, and oDone follows on the next cycle.
// - Width rules: col/row counters are $clog2(IMG_W)/$clog2(IMG_H) bits. No arithmetic on
//   pixel data in this block.
// TESTING (bench: IMG_W=5, IMG_H=5, MED_LAT=3, behavioural median model)
// 1 Reset: hold iRst_n=0 while driving pixels -> oPixelReady=0, oPixelValid=0, oBusy=0, oP*=0.
// 2 Single window: 3x3 frame (IMG_W=IMG_H=3) rows {0,3,2},{2,2,2},{4,10,1} -> oP11..oP33 =
//   0,3,2,2,2,2,4,10,1. One output = 2, 3 cycles after the last accept, oDone next cycle.
// 3 Full 5x5 frame, pixel = 5*row+col, no stalls -> 9 outputs 6,7,8,11,12,13,16,17,18 in order.
//   oBusy falls when oDone pulses.
// 4 Same frame with iPixelValid low every 3rd cycle -> identical 9 values.
//   No window straddles a line (check col-0 reset).
// 5 Reset mid-frame: assert iRst_n=0 after 12 accepts. Then iStart + full frame
//   {5,33,32,11,2,8,7,78,9,...} -> state IDLE at reset, second frame outputs match model exactly.
// 6 iStart pulsed during RUN and in the DONE cycle -> ignored. Pixels offered in DRAIN are
//   not accepted (oPixelReady=0). Next iStart from IDLE starts a clean frame.

Source files
------------

// File: rtl/median_window_ctrl.sv
`timescale 1ns/1ps
// median_window_ctrl
// Raster-stream sequencer for a 3x3 median datapath. Keeps two line buffers,
// presents each complete 3x3 window on oP11..oP33, and re-times the datapath
// result with a delayed valid so only the interior of each frame is emitted.
module median_window_ctrl #(
  parameter int DW      = 8,
  parameter int IMG_W   = 640,
  parameter int IMG_H   = 480,
  parameter int MED_LAT = 3
) (
  input  logic          iClk,
  input  logic          iRst_n,
  input  logic          iStart,
  input  logic [DW-1:0] iPixel,
  input  logic          iPixelValid,
  output logic          oPixelReady,
  output logic [DW-1:0] oP11,
  output logic [DW-1:0] oP12,
  output logic [DW-1:0] oP13,
  output logic [DW-1:0] oP21,
  output logic [DW-1:0] oP22,
  output logic [DW-1:0] oP23,
  output logic [DW-1:0] oP31,
  output logic [DW-1:0] oP32,
  output logic [DW-1:0] oP33,
  input  logic [DW-1:0] iMedianValue,
  output logic [DW-1:0] oPixel,
  output logic          oPixelValid,
  output logic          oBusy,
  output logic          oDone
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int LW = (MED_LAT > 1) ? $clog2(MED_LAT) : 1;
  localparam logic [CW-1:0] COL_LAST   = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST   = RW'(IMG_H - 1);
  localparam logic [LW-1:0] DRAIN_LAST = LW'(MED_LAT - 1);

  typedef enum logic [2:0] {IDLE, FILL, RUN, DRAIN, DONE} stateT;

  stateT          state;
  logic [LW-1:0]  drainCnt;
  logic [CW-1:0]  col;
  logic [CW-1:0]  colNext;
  logic [RW-1:0]  row;
  logic           accept;
  logic           lastPix;
  logic           windowValid;

  // Line buffers: lineBuf1 holds line r-1, lineBuf0 holds line r-2
  logic [DW-1:0]  lineBuf0 [IMG_W];
  logic [DW-1:0]  lineBuf1 [IMG_W];
  logic [DW-1:0]  lb0Rd;
  logic [DW-1:0]  lb1Rd;
  logic [CW-1:0]  rdAddr;

  logic [DW-1:0]  winL [3];
  logic [DW-1:0]  winM [3];
  logic [DW-1:0]  winR [3];

  logic [MED_LAT-1:0] validPipe;
  logic               captureEn;

  assign accept      = iPixelValid && oPixelReady;
  assign lastPix     = (col == COL_LAST) && (row == ROW_LAST);
  assign windowValid = accept && (row >= RW'(2)) && (col >= CW'(2));
  assign colNext     = (col == COL_LAST) ? '0 : col + CW'(1);

  // The read port always points at the column the next accept will use, so
  // the registered read data is ready by the time that pixel arrives. During
  // a stall the address holds at the current column.
  assign rdAddr = accept ? colNext : col;

  // Frame sequencer: state plus its registered handshake/status outputs
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state       <= IDLE;
      drainCnt    <= '0;
      oPixelReady <= 1'b0;
      oBusy       <= 1'b0;
      oDone       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          oDone <= 1'b0;
          if (iStart) begin
            state       <= FILL;
            oPixelReady <= 1'b1;
            oBusy       <= 1'b1;
          end
        end
        FILL, RUN: begin
          if (accept) begin
            if (lastPix) begin
              // Last pixel of the frame may also be the first window (3x3 image)
              state       <= DRAIN;
              drainCnt    <= '0;
              oPixelReady <= 1'b0;
            end else if ((state == FILL) && (row == RW'(2)) && (col == CW'(2))) begin
              state <= RUN;
            end
          end
        end
        DRAIN: begin
          if (drainCnt == DRAIN_LAST) begin
            state <= DONE;
            oBusy <= 1'b0;
            oDone <= 1'b1;
          end else begin
            drainCnt <= drainCnt + LW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          oDone <= 1'b0;
        end
        default: begin
          state       <= IDLE;
          oPixelReady <= 1'b0;
          oBusy       <= 1'b0;
          oDone       <= 1'b0;
        end
      endcase
    end
  end

  // Raster position: advances only on accepted pixels, wraps at frame end
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      col <= '0;
      row <= '0;
    end else if ((state == IDLE) && iStart) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      col <= colNext;
      if (col == COL_LAST) begin
        row <= (row == ROW_LAST) ? '0 : row + RW'(1);
      end
    end
  end

  // Line-buffer RAMs: registered read, older line rolls from lineBuf1 into lineBuf0
  always_ff @(posedge iClk) begin
    if (accept) begin
      lineBuf0[col] <= lb1Rd;
      lineBuf1[col] <= iPixel;
    end
    lb0Rd <= lineBuf0[rdAddr];
    lb1Rd <= lineBuf1[rdAddr];
  end

  // One 3-tap shift register per window row; row 0 is the oldest line
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : gRow
      logic [DW-1:0] tapIn;
      logic [DW-1:0] tapL;
      logic [DW-1:0] tapM;
      logic [DW-1:0] tapR;

      if (gi == 0) begin : gSrc
        assign tapIn = lb0Rd;
      end else if (gi == 1) begin : gSrc
        assign tapIn = lb1Rd;
      end else begin : gSrc
        assign tapIn = iPixel;
      end

      // Shift on accept; clear older taps at column 0 so no window spans a line wrap
      always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
          tapL <= '0;
          tapM <= '0;
          tapR <= '0;
        end else if (accept) begin
          if (col == '0) begin
            tapL <= '0;
            tapM <= '0;
          end else begin
            tapL <= tapM;
            tapM <= tapR;
          end
          tapR <= tapIn;
        end
      end

      assign winL[gi] = tapL;
      assign winM[gi] = tapM;
      assign winR[gi] = tapR;
    end
  endgenerate

  assign oP11 = winL[0];
  assign oP12 = winM[0];
  assign oP13 = winR[0];
  assign oP21 = winL[1];
  assign oP22 = winM[1];
  assign oP23 = winR[1];
  assign oP31 = winL[2];
  assign oP32 = winM[2];
  assign oP33 = winR[2];

  // Window-valid delay line matching the datapath latency; shifts every cycle
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      validPipe <= '0;
    end else begin
      validPipe[0] <= windowValid;
      for (int i = 1; i < MED_LAT; i++) begin
        validPipe[i] <= validPipe[i-1];
      end
    end
  end

  // The result is captured one stage before the tail so that oPixel and
  // oPixelValid change on the same edge.
  generate
    if (MED_LAT == 1) begin : gCapDirect
      assign captureEn = windowValid;
    end else begin : gCapPipe
      assign captureEn = validPipe[MED_LAT-2];
    end
  endgenerate

  assign oPixelValid = validPipe[MED_LAT-1];

  // Output pixel register: loads the datapath result, holds otherwise
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      oPixel <= '0;
    end else if (captureEn) begin
      oPixel <= iMedianValue;
    end
  end

endmodule

// File: tb/tb_median_window_ctrl.sv
`timescale 1ns/1ps
// Bench for median_window_ctrl: a 5x5 instance for frame-level scenarios and
// a 3x3 instance for the single-window case, each fed by a median stand-in.
module tb_median_window_ctrl;

  localparam int MED_LAT = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstN = 1'b0;
  int   checks = 0;
  int   errors = 0;

  // ---------------- 5x5 instance ----------------
  logic       start5 = 1'b0;
  logic       valid5 = 1'b0;
  logic [7:0] pix5   = '0;
  logic       ready5, pv5, busy5, done5;
  logic [7:0] op5;
  logic [7:0] w5 [9];
  logic [7:0] med5Q = '0;

  median_window_ctrl #(.DW(8), .IMG_W(5), .IMG_H(5), .MED_LAT(MED_LAT)) dut5 (
    .iClk(clk), .iRst_n(rstN), .iStart(start5), .iPixel(pix5), .iPixelValid(valid5),
    .oPixelReady(ready5),
    .oP11(w5[0]), .oP12(w5[1]), .oP13(w5[2]),
    .oP21(w5[3]), .oP22(w5[4]), .oP23(w5[5]),
    .oP31(w5[6]), .oP32(w5[7]), .oP33(w5[8]),
    .iMedianValue(med5Q), .oPixel(op5), .oPixelValid(pv5), .oBusy(busy5), .oDone(done5)
  );

  // ---------------- 3x3 instance ----------------
  logic       start3 = 1'b0;
  logic       valid3 = 1'b0;
  logic [7:0] pix3   = '0;
  logic       ready3, pv3, busy3, done3;
  logic [7:0] op3;
  logic [7:0] w3 [9];
  logic [7:0] med3Q = '0;

  median_window_ctrl #(.DW(8), .IMG_W(3), .IMG_H(3), .MED_LAT(MED_LAT)) dut3 (
    .iClk(clk), .iRst_n(rstN), .iStart(start3), .iPixel(pix3), .iPixelValid(valid3),
    .oPixelReady(ready3),
    .oP11(w3[0]), .oP12(w3[1]), .oP13(w3[2]),
    .oP21(w3[3]), .oP22(w3[4]), .oP23(w3[5]),
    .oP31(w3[6]), .oP32(w3[7]), .oP33(w3[8]),
    .iMedianValue(med3Q), .oPixel(op3), .oPixelValid(pv3), .oBusy(busy3), .oDone(done3)
  );

  function automatic logic [7:0] median9(input logic [7:0] a [9]);
    logic [7:0] s [9];
    logic [7:0] t;
    s = a;
    for (int i = 0; i < 9; i++)
      for (int j = 0; j < 8 - i; j++)
        if (s[j] > s[j+1]) begin
          t = s[j]; s[j] = s[j+1]; s[j+1] = t;
        end
    return s[4];
  endfunction

  // Datapath stand-in: median of the presented window behind one register,
  // so an accepted window reaches iMedianValue two edges after its accept and
  // the controller's output register completes the MED_LAT=3 path.
  always @(posedge clk) begin
    med5Q <= median9(w5);
    med3Q <= median9(w3);
  end

  // Output collector for the 5x5 instance
  logic [7:0] outQ5 [$];
  always @(negedge clk) if (pv5) outQ5.push_back(op5);

  // Reference model: median of every 3x3 neighbourhood of the interior, raster order
  logic [7:0] frame5 [25];
  logic [7:0] expQ5 [$];
  function automatic void buildExpect5();
    logic [7:0] a [9];
    expQ5.delete();
    for (int r = 1; r <= 3; r++)
      for (int c = 1; c <= 3; c++) begin
        for (int k = 0; k < 9; k++) a[k] = frame5[(r - 1 + k / 3) * 5 + (c - 1 + k % 3)];
        expQ5.push_back(median9(a));
      end
  endfunction

  task automatic pulseStart5();
    start5 = 1'b1;
    @(posedge clk); #1;
    start5 = 1'b0;
  endtask

  // Offers frame5 pixels until nAcc are accepted; stallEvery>0 drops valid every Nth cycle
  task automatic drive5(input int stallEvery, input int nAcc, input int startAt, output int got);
    int  idx = 0;
    int  cyc = 0;
    logic acc;
    while (idx < nAcc && cyc < 400) begin
      valid5 = (stallEvery == 0) || (cyc % stallEvery != stallEvery - 1);
      pix5   = frame5[idx];
      start5 = (idx == startAt);
      @(negedge clk);
      acc = valid5 && ready5;
      @(posedge clk); #1;
      if (acc) idx++;
      cyc++;
    end
    valid5 = 1'b0;
    start5 = 1'b0;
    got = idx;
  endtask

  task automatic waitDone5(output int cyc, output logic busyAt, output logic busyPrev);
    cyc = -1;
    busyAt = 1'b1;
    busyPrev = busy5;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done5) begin
        cyc = k;
        busyAt = busy5;
        break;
      end
      busyPrev = busy5;
    end
  endtask

  task automatic test_reset();
    rstN = 1'b0;
    start5 = 1'b1; valid5 = 1'b1; start3 = 1'b1; valid3 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pix5 = 8'($urandom); pix3 = 8'($urandom);
      @(negedge clk);
      checks++; if (ready5 !== 1'b0) begin errors++; $display("FAIL reset_ready got=%0d exp=0", ready5); end
      checks++; if (pv5 !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0d exp=0", pv5); end
      checks++; if (busy5 !== 1'b0 || done5 !== 1'b0) begin errors++; $display("FAIL reset_busy_done got=%0d/%0d exp=0/0", busy5, done5); end
      checks++; if (ready3 !== 1'b0 || busy3 !== 1'b0) begin errors++; $display("FAIL reset_dut3 got=%0d/%0d exp=0/0", ready3, busy3); end
      for (int k = 0; k < 9; k++) begin
        checks++; if (w5[k] !== 8'd0) begin errors++; $display("FAIL reset_window[%0d] got=%0d exp=0", k, w5[k]); end
      end
      @(posedge clk); #1;
    end
    start5 = 1'b0; valid5 = 1'b0; start3 = 1'b0; valid3 = 1'b0;
    rstN = 1'b1;
    @(negedge clk);
    checks++; if (busy5 !== 1'b0) begin errors++; $display("FAIL reset_release_busy got=%0d exp=0", busy5); end
    @(posedge clk); #1;
  endtask

  task automatic test_single_window();
    logic [7:0] img [9];
    logic [7:0] expWin [9];
    img    = '{8'd0, 8'd3, 8'd2, 8'd2, 8'd2, 8'd2, 8'd4, 8'd10, 8'd1};
    expWin = img;
    start3 = 1'b1;
    @(posedge clk); #1;
    start3 = 1'b0;
    for (int i = 0; i < 9; i++) begin
      valid3 = 1'b1; pix3 = img[i];
      @(negedge clk);
      checks++; if (ready3 !== 1'b1) begin errors++; $display("FAIL single_ready px=%0d got=%0d exp=1", i, ready3); end
      @(posedge clk); #1;
    end
    valid3 = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) begin
        for (int j = 0; j < 9; j++) begin
          checks++; if (w3[j] !== expWin[j]) begin errors++; $display("FAIL single_window[%0d] got=%0d exp=%0d", j, w3[j], expWin[j]); end
        end
        checks++; if (ready3 !== 1'b0) begin errors++; $display("FAIL single_ready_drain got=%0d exp=0", ready3); end
      end
      checks++; if (pv3 !== (k == 3)) begin errors++; $display("FAIL single_valid cyc=%0d got=%0d exp=%0d", k, pv3, (k == 3)); end
      if (k == 3) begin
        checks++; if (op3 !== 8'd2) begin errors++; $display("FAIL single_median got=%0d exp=2", op3); end
      end
      checks++; if (done3 !== (k == 4)) begin errors++; $display("FAIL single_done cyc=%0d got=%0d exp=%0d", k, done3, (k == 4)); end
      checks++; if (busy3 !== (k <= 3)) begin errors++; $display("FAIL single_busy cyc=%0d got=%0d exp=%0d", k, busy3, (k <= 3)); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_full_frame();
    int got, cyc;
    logic bAt, bPrev;
    logic [7:0] ramp [9];
    ramp = '{8'd6, 8'd7, 8'd8, 8'd11, 8'd12, 8'd13, 8'd16, 8'd17, 8'd18};
    for (int i = 0; i < 25; i++) frame5[i] = 8'(i);
    buildExpect5();
    outQ5.delete();
    pulseStart5();
    drive5(0, 25, -1, got);
    checks++; if (got != 25) begin errors++; $display("FAIL full_accepts got=%0d exp=25", got); end
    waitDone5(cyc, bAt, bPrev);
    checks++; if (cyc < 0) begin errors++; $display("FAIL full_done_timeout got=none exp=pulse"); end
    checks++; if (bAt !== 1'b0 || bPrev !== 1'b1) begin errors++; $display("FAIL full_busy_fall got=%0d->%0d exp=1->0", bPrev, bAt); end
    checks++; if (outQ5.size() != 9) begin errors++; $display("FAIL full_count got=%0d exp=9", outQ5.size()); end
    for (int i = 0; i < 9 && i < outQ5.size(); i++) begin
      checks++; if (outQ5[i] !== expQ5[i] || outQ5[i] !== ramp[i]) begin errors++; $display("FAIL full_pixel[%0d] got=%0d exp=%0d", i, outQ5[i], ramp[i]); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_stalls();
    int got, cyc;
    logic bAt, bPrev;
    for (int i = 0; i < 25; i++) frame5[i] = 8'(i);
    buildExpect5();
    outQ5.delete();
    pulseStart5();
    drive5(3, 25, -1, got);
    checks++; if (got != 25) begin errors++; $display("FAIL stall_accepts got=%0d exp=25", got); end
    waitDone5(cyc, bAt, bPrev);
    checks++; if (cyc < 0) begin errors++; $display("FAIL stall_done_timeout got=none exp=pulse"); end
    checks++; if (outQ5.size() != 9) begin errors++; $display("FAIL stall_count got=%0d exp=9", outQ5.size()); end
    for (int i = 0; i < 9 && i < outQ5.size(); i++) begin
      checks++; if (outQ5[i] !== expQ5[i]) begin errors++; $display("FAIL stall_pixel[%0d] got=%0d exp=%0d", i, outQ5[i], expQ5[i]); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midframe();
    int got, cyc;
    logic bAt, bPrev;
    logic [7:0] head [9];
    head = '{8'd5, 8'd33, 8'd32, 8'd11, 8'd2, 8'd8, 8'd7, 8'd78, 8'd9};
    for (int i = 0; i < 25; i++) frame5[i] = 8'($urandom);
    outQ5.delete();
    pulseStart5();
    drive5(0, 12, -1, got);
    checks++; if (got != 12) begin errors++; $display("FAIL mid_accepts got=%0d exp=12", got); end
    rstN = 1'b0;
    @(negedge clk);
    checks++; if (busy5 !== 1'b0 || ready5 !== 1'b0 || pv5 !== 1'b0) begin errors++; $display("FAIL mid_reset_idle got=%0d/%0d/%0d exp=0/0/0", busy5, ready5, pv5); end
    @(posedge clk); #1;
    rstN = 1'b1;
    @(negedge clk);
    checks++; if (busy5 !== 1'b0 || ready5 !== 1'b0) begin errors++; $display("FAIL mid_release_idle got=%0d/%0d exp=0/0", busy5, ready5); end
    @(posedge clk); #1;
    for (int i = 0; i < 25; i++) frame5[i] = (i < 9) ? head[i] : 8'($urandom);
    buildExpect5();
    outQ5.delete();
    pulseStart5();
    drive5(0, 25, -1, got);
    checks++; if (got != 25) begin errors++; $display("FAIL mid_frame_accepts got=%0d exp=25", got); end
    waitDone5(cyc, bAt, bPrev);
    checks++; if (cyc < 0) begin errors++; $display("FAIL mid_done_timeout got=none exp=pulse"); end
    checks++; if (outQ5.size() != 9) begin errors++; $display("FAIL mid_count got=%0d exp=9", outQ5.size()); end
    for (int i = 0; i < 9 && i < outQ5.size(); i++) begin
      checks++; if (outQ5[i] !== expQ5[i]) begin errors++; $display("FAIL mid_pixel[%0d] got=%0d exp=%0d", i, outQ5[i], expQ5[i]); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_ignored_start();
    int got, cyc, drainCycles;
    logic bAt, bPrev, doneSeen;
    for (int i = 0; i < 25; i++) frame5[i] = 8'($urandom);
    buildExpect5();
    outQ5.delete();
    pulseStart5();
    drive5(0, 25, 15, got);
    checks++; if (got != 25) begin errors++; $display("FAIL ign_accepts got=%0d exp=25", got); end
    drainCycles = 0;
    doneSeen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      valid5 = 1'b1; pix5 = 8'($urandom);
      @(negedge clk);
      if (done5) begin doneSeen = 1'b1; break; end
      checks++; if (ready5 !== 1'b0) begin errors++; $display("FAIL ign_drain_ready cyc=%0d got=%0d exp=0", k, ready5); end
      drainCycles++;
      @(posedge clk); #1;
    end
    checks++; if (!doneSeen || drainCycles != MED_LAT) begin errors++; $display("FAIL ign_drain_len got=%0d exp=%0d", drainCycles, MED_LAT); end
    start5 = 1'b1; valid5 = 1'b0;
    @(posedge clk); #1;
    start5 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (busy5 !== 1'b0 || ready5 !== 1'b0) begin errors++; $display("FAIL ign_done_start got=%0d/%0d exp=0/0", busy5, ready5); end
    end
    checks++; if (outQ5.size() != 9) begin errors++; $display("FAIL ign_count got=%0d exp=9", outQ5.size()); end
    for (int i = 0; i < 9 && i < outQ5.size(); i++) begin
      checks++; if (outQ5[i] !== expQ5[i]) begin errors++; $display("FAIL ign_pixel[%0d] got=%0d exp=%0d", i, outQ5[i], expQ5[i]); end
    end
    @(posedge clk); #1;
    // A clean frame started from IDLE
    for (int i = 0; i < 25; i++) frame5[i] = 8'($urandom);
    buildExpect5();
    outQ5.delete();
    pulseStart5();
    drive5(0, 25, -1, got);
    waitDone5(cyc, bAt, bPrev);
    checks++; if (cyc < 0 || got != 25) begin errors++; $display("FAIL clean_frame_done got=%0d/%0d exp=done/25", cyc, got); end
    checks++; if (outQ5.size() != 9) begin errors++; $display("FAIL clean_count got=%0d exp=9", outQ5.size()); end
    for (int i = 0; i < 9 && i < outQ5.size(); i++) begin
      checks++; if (outQ5[i] !== expQ5[i]) begin errors++; $display("FAIL clean_pixel[%0d] got=%0d exp=%0d", i, outQ5[i], expQ5[i]); end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_single_window();
    test_full_frame();
    test_stalls();
    test_reset_midframe();
    test_ignored_start();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
